// File: rtl/tilt_direction_decoder.sv
// Tilt direction decoder: per-axis hysteresis FSM + N-sample debounce, stop key sync.
// Optional sample-stream watchdog compiled in with `define TILT_WATCHDOG_EN.
module tilt_direction_decoder #(
  parameter int SAMPLE_W    = 16,
  parameter int THRESH_ON   = 64,
  parameter int THRESH_OFF  = 48,
  parameter int STABLE_CNT  = 3,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iSAMPLE_VALID,
  input  logic [SAMPLE_W-1:0] iACC_X,
  input  logic [SAMPLE_W-1:0] iACC_Y,
  input  logic                iKEY_STOP_N,
  output logic [1:0]          data_x,
  output logic [1:0]          data_y,
  output logic                data_stop,
  output logic                oTIMEOUT
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_NEG  = 2'b10;
  localparam logic [1:0] ST_POS  = 2'b11;

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CNT);

  // One extra bit so that -2^(SAMPLE_W-1) and the negated thresholds compare cleanly.
  localparam logic signed [SAMPLE_W:0] ON_POS  = (SAMPLE_W+1)'(THRESH_ON);
  localparam logic signed [SAMPLE_W:0] ON_NEG  = -ON_POS;
  localparam logic signed [SAMPLE_W:0] OFF_POS = (SAMPLE_W+1)'(THRESH_OFF);
  localparam logic signed [SAMPLE_W:0] OFF_NEG = -OFF_POS;

  logic       wd_force;
  logic [1:0] axis_state [2];

`ifdef TILT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            timeout_reg;
  logic            timeout_next;

  always_comb begin
    timeout_next = timeout_reg;
    if (iSAMPLE_VALID)
      timeout_next = 1'b0;
    else if (wd_cnt_reg == WD_LIMIT)
      timeout_next = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
      if (iSAMPLE_VALID)
        wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_LIMIT)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  // Forcing tracks the next timeout value so outputs and oTIMEOUT change together,
  // and a valid sample is never swallowed by the force.
  assign wd_force = timeout_next;
  assign oTIMEOUT = timeout_reg;
`else
  assign wd_force = 1'b0;
  assign oTIMEOUT = 1'b0;
`endif

  logic key_sync1_reg;
  logic key_sync2_reg;
  logic data_stop_reg;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      key_sync1_reg <= 1'b1;
      key_sync2_reg <= 1'b1;
      data_stop_reg <= 1'b0;
    end else begin
      key_sync1_reg <= iKEY_STOP_N;
      key_sync2_reg <= key_sync1_reg;
      data_stop_reg <= ~key_sync2_reg | wd_force;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [SAMPLE_W-1:0]      sample_raw;
      logic signed [SAMPLE_W:0] sample_ext;
      logic [1:0]               state_reg;
      logic [1:0]               pend_reg;
      logic [1:0]               cand;
      logic [CNT_W-1:0]         cnt_reg;
      logic [CNT_W-1:0]         cnt_new;

      assign sample_raw = (gi == 0) ? iACC_X : iACC_Y;
      assign sample_ext = {sample_raw[SAMPLE_W-1], sample_raw};

      always_comb begin
        cand = ST_IDLE;
        case (state_reg)
          ST_IDLE: begin
            if (sample_ext >= ON_POS)      cand = ST_POS;
            else if (sample_ext <= ON_NEG) cand = ST_NEG;
            else                           cand = ST_IDLE;
          end
          ST_POS: begin
            if (sample_ext <= ON_NEG)      cand = ST_NEG;
            else if (sample_ext < OFF_POS) cand = ST_IDLE;
            else                           cand = ST_POS;
          end
          ST_NEG: begin
            if (sample_ext >= ON_POS)      cand = ST_POS;
            else if (sample_ext > OFF_NEG) cand = ST_IDLE;
            else                           cand = ST_NEG;
          end
          default: cand = ST_IDLE;
        endcase
      end

      assign cnt_new = (cand == pend_reg) ? cnt_reg + 1'b1 : CNT_W'(1);

      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          state_reg <= ST_IDLE;
          pend_reg  <= ST_IDLE;
          cnt_reg   <= '0;
        end else if (wd_force) begin
          state_reg <= ST_IDLE;
          pend_reg  <= ST_IDLE;
          cnt_reg   <= '0;
        end else if (iSAMPLE_VALID) begin
          if (cand == state_reg) begin
            cnt_reg <= '0;
          end else begin
            pend_reg <= cand;
            if (cnt_new == CNT_DONE) begin
              state_reg <= cand;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_new;
            end
          end
        end
      end

      assign axis_state[gi] = state_reg;
    end
  endgenerate

  assign data_x    = axis_state[0];
  assign data_y    = axis_state[1];
  assign data_stop = data_stop_reg;

endmodule

// File: tb/tb_tilt_direction_decoder.sv
// Directed bench for tilt_direction_decoder; watchdog scenario chosen by TILT_WATCHDOG_EN.
module tb_tilt_direction_decoder;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iSAMPLE_VALID = 1'b0;
  logic [15:0] iACC_X = '0;
  logic [15:0] iACC_Y = '0;
  logic        iKEY_STOP_N = 1'b1;
  logic [1:0]  data_x;
  logic [1:0]  data_y;
  logic        data_stop;
  logic        oTIMEOUT;

  int tests_run = 0;
  int tests_failed = 0;

  tilt_direction_decoder #(
    .SAMPLE_W(16), .THRESH_ON(64), .THRESH_OFF(48),
    .STABLE_CNT(3), .TIMEOUT_CYC(100)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSAMPLE_VALID(iSAMPLE_VALID),
    .iACC_X(iACC_X), .iACC_Y(iACC_Y), .iKEY_STOP_N(iKEY_STOP_N),
    .data_x(data_x), .data_y(data_y), .data_stop(data_stop), .oTIMEOUT(oTIMEOUT)
  );

  always #5 iCLK = ~iCLK;

  // Inputs change 1ns after a rising edge; outputs are read at the same point.
  task automatic strobe(input int x, input int y);
    iSAMPLE_VALID = 1'b1;
    iACC_X = 16'(x);
    iACC_Y = 16'(y);
    @(posedge iCLK); #1;
    iSAMPLE_VALID = 1'b0;
    $display("[TB] t=%0t sample x=%0d y=%0d -> data_x=%b data_y=%b stop=%b timeout=%b",
             $time, x, y, data_x, data_y, data_stop, oTIMEOUT);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic test_reset;
    iRST_N = 1'b0;
    idle(2);
    tests_run++;
    if ({data_x, data_y, data_stop, oTIMEOUT} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, expected 000000", {data_x, data_y, data_stop, oTIMEOUT});
    end
    iRST_N = 1'b1;
    idle(1);
    tests_run++;
    if ({data_x, data_y, data_stop} !== 5'b0) begin
      tests_failed++;
      $display("FAIL post_reset_outputs: got %b, expected 00000", {data_x, data_y, data_stop});
    end
  endtask

  task automatic test_basic_right;
    strobe(100, 0);
    strobe(100, 0);
    tests_run++;
    if (data_x !== 2'b00) begin
      tests_failed++;
      $display("FAIL right_before_commit: data_x=%b, expected 00", data_x);
    end
    strobe(100, 0);
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL right_commit: data_x=%b, expected 11", data_x);
    end
    tests_run++;
    if (data_y !== 2'b00) begin
      tests_failed++;
      $display("FAIL right_commit_y: data_y=%b, expected 00", data_y);
    end
  endtask

  task automatic test_debounce_y;
    strobe(100, -70);
    strobe(100, -70);
    strobe(100, 0);
    strobe(100, -70);
    strobe(100, -70);
    tests_run++;
    if (data_y !== 2'b00) begin
      tests_failed++;
      $display("FAIL debounce_interrupted: data_y=%b, expected 00", data_y);
    end
    strobe(100, -70);
    tests_run++;
    if (data_y !== 2'b10) begin
      tests_failed++;
      $display("FAIL debounce_down_commit: data_y=%b, expected 10", data_y);
    end
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL debounce_x_hold: data_x=%b, expected 11", data_x);
    end
  endtask

  task automatic test_hysteresis;
    for (int i = 0; i < 5; i++) strobe(50, -70);
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL hyst_hold_50: data_x=%b, expected 11", data_x);
    end
    strobe(40, -70);
    strobe(40, -70);
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL hyst_release_pending: data_x=%b, expected 11", data_x);
    end
    strobe(40, -70);
    tests_run++;
    if (data_x !== 2'b00) begin
      tests_failed++;
      $display("FAIL hyst_release: data_x=%b, expected 00", data_x);
    end
    strobe(-64, -70);
    strobe(-64, -70);
    tests_run++;
    if (data_x !== 2'b00) begin
      tests_failed++;
      $display("FAIL left_pending: data_x=%b, expected 00", data_x);
    end
    strobe(-64, -70);
    tests_run++;
    if (data_x !== 2'b10) begin
      tests_failed++;
      $display("FAIL left_commit_at_threshold: data_x=%b, expected 10", data_x);
    end
    for (int i = 0; i < 3; i++) strobe(-32768, -70);
    tests_run++;
    if (data_x !== 2'b10) begin
      tests_failed++;
      $display("FAIL most_negative_holds_left: data_x=%b, expected 10", data_x);
    end
    for (int i = 0; i < 3; i++) strobe(100, -70);
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL left_to_right: data_x=%b, expected 11", data_x);
    end
  endtask

  task automatic test_stop_key;
    logic exp_stop;
    iKEY_STOP_N = 1'b0;
    for (int i = 0; i < 10; i++) begin
      strobe(100, -70);
      exp_stop = (i >= 2);
      tests_run++;
      if (data_stop !== exp_stop || data_x !== 2'b11) begin
        tests_failed++;
        $display("FAIL stop_held[%0d]: data_stop=%b data_x=%b, expected %b 11", i, data_stop, data_x, exp_stop);
      end
    end
    iKEY_STOP_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(100, -70);
      exp_stop = (i < 2);
      tests_run++;
      if (data_stop !== exp_stop) begin
        tests_failed++;
        $display("FAIL stop_release[%0d]: data_stop=%b, expected %b", i, data_stop, exp_stop);
      end
    end
  endtask

`ifdef TILT_WATCHDOG_EN
  task automatic test_watchdog;
    idle(100);
    tests_run++;
    if (oTIMEOUT !== 1'b0 || data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL wd_before_expiry: timeout=%b data_x=%b, expected 0 11", oTIMEOUT, data_x);
    end
    idle(1);
    tests_run++;
    if ({oTIMEOUT, data_stop, data_x, data_y} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL wd_expired: got %b, expected 110000", {oTIMEOUT, data_stop, data_x, data_y});
    end
    idle(20);
    strobe(100, 0);
    tests_run++;
    if ({oTIMEOUT, data_stop, data_x} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL wd_recover_first: got %b, expected 0000", {oTIMEOUT, data_stop, data_x});
    end
    strobe(100, 0);
    strobe(100, 0);
    tests_run++;
    if (data_x !== 2'b11) begin
      tests_failed++;
      $display("FAIL wd_recover_commit: data_x=%b, expected 11", data_x);
    end
  endtask
`else
  task automatic test_no_watchdog;
    idle(1000);
    tests_run++;
    if ({oTIMEOUT, data_stop, data_x} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL no_watchdog_idle: got %b, expected 0011", {oTIMEOUT, data_stop, data_x});
    end
  endtask
`endif

  task automatic test_reset_mid_debounce;
    strobe(-100, 100);
    strobe(-100, 100);
    #3;
    iRST_N = 1'b0;
    #1;
    tests_run++;
    if ({data_x, data_y, data_stop, oTIMEOUT} !== 6'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %b, expected 000000", {data_x, data_y, data_stop, oTIMEOUT});
    end
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    strobe(-100, 100);
    tests_run++;
    if (data_x !== 2'b00) begin
      tests_failed++;
      $display("FAIL pending_discarded: data_x=%b, expected 00", data_x);
    end
    strobe(-100, 100);
    strobe(-100, 100);
    tests_run++;
    if (data_x !== 2'b10 || data_y !== 2'b11) begin
      tests_failed++;
      $display("FAIL both_axes_commit: data_x=%b data_y=%b, expected 10 11", data_x, data_y);
    end
  endtask

  initial begin
    @(posedge iCLK); #1;
    test_reset();
    test_basic_right();
    test_debounce_y();
    test_hysteresis();
    test_stop_key();
`ifdef TILT_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
